inv_sbox_seq: RTL and testbench

- Sequential inverse SubBytes engine: applies the AES inverse S-box to all 16 bytes of a 128-bit state, LANES bytes per clock.
- Inverse S-box = inverse affine transform followed by GF(2^8) multiplicative inverse computed in composite field GF((2^4)^2).
- Uses the same field basis and isomorphism as the forward composite-field SBOX, so the two blocks are exact inverses.
- Sits in the decryption datapath between InvShiftRows and AddRoundKey. Uses valid/ready handshakes on both sides.

---
 rtl/inv_sbox_seq.sv | 218 +++++++++++++++++++++
 tb/tb_inv_sbox_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sbox_seq.sv
// Sequential AES inverse SubBytes engine: LANES bytes of the 128-bit state per clock,
// each byte through inverse affine + composite-field GF((2^4)^2) inversion.
module inv_sbox_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    // GF(2^4) uses x^4+x+1; the extension uses y^2+y+LAMBDA (trace of LAMBDA is 1, so irreducible).
    localparam logic [3:0] LAMBDA = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            acc = acc ^ (sh & {4{b[i]}});
            sh  = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    // a^14 == a^-1 in GF(16), and maps 0 to 0.
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2;
        logic [3:0] a4;
        logic [3:0] a8;
        a2 = gf16_mul(a, a);
        a4 = gf16_mul(a2, a2);
        a8 = gf16_mul(a4, a4);
        return gf16_mul(gf16_mul(a8, a4), a2);
    endfunction

    function automatic logic [7:0] gfc_mul(input logic [7:0] p, input logic [7:0] q);
        logic [3:0] hh;
        hh = gf16_mul(p[7:4], q[7:4]);
        return {hh ^ gf16_mul(p[7:4], q[3:0]) ^ gf16_mul(p[3:0], q[7:4]),
                gf16_mul(LAMBDA, hh) ^ gf16_mul(p[3:0], q[3:0])};
    endfunction

    // (b*y + c)^-1 = (b*y + b + c) / (LAMBDA*b^2 + c*(b+c))
    function automatic logic [7:0] gfc_inv(input logic [7:0] p);
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d_inv;
        b     = p[7:4];
        c     = p[3:0];
        d_inv = gf16_inv(gf16_mul(LAMBDA, gf16_mul(b, b)) ^ gf16_mul(c, b ^ c));
        return {gf16_mul(b, d_inv), gf16_mul(b ^ c, d_inv)};
    endfunction

    function automatic logic [7:0] iso_map(input logic [7:0] a, input logic [63:0] cols);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r = r ^ (cols[8*i +: 8] & {8{a[i]}});
        end
        return r;
    endfunction

    // Isomorphism columns are powers beta^0..beta^7 of the smallest root of t^8+t^4+t^3+t+1.
    function automatic logic [63:0] iso_cols();
        logic [63:0] cols;
        logic [63:0] cand;
        logic [7:0]  pw;
        logic [7:0]  acc;
        cols = 64'h0;
        for (int r = 255; r > 0; r--) begin
            pw   = 8'h01;
            acc  = 8'h00;
            cand = 64'h0;
            for (int i = 0; i < 8; i++) begin
                cand[8*i +: 8] = pw;
                acc = acc ^ ((i == 0 || i == 1 || i == 3 || i == 4) ? pw : 8'h00);
                pw  = gfc_mul(pw, 8'(r));
            end
            acc  = acc ^ pw;
            cols = (acc == 8'h00) ? cand : cols;
        end
        return cols;
    endfunction

    function automatic logic [63:0] iso_inv_cols(input logic [63:0] cols);
        logic [63:0] inv;
        inv = 64'h0;
        for (int j = 0; j < 8; j++) begin
            for (int v = 1; v < 256; v++) begin
                inv[8*j +: 8] = (iso_map(8'(v), cols) == (8'h01 << j)) ? 8'(v) : inv[8*j +: 8];
            end
        end
        return inv;
    endfunction

    localparam logic [63:0] ISO     = iso_cols();
    localparam logic [63:0] ISO_INV = iso_inv_cols(ISO);

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return iso_map(gfc_inv(iso_map(t, ISO)), ISO_INV);
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [127:0]    work_r;
    logic [127:0]    work_s;
    logic [127:0]    out_data_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    // Substitute the lane group selected by the counter; other bytes pass through.
    always_comb begin
        work_s = work_r;
        for (int l = 0; l < LANES; l++) begin
            work_s[(int'(cnt_r) * LANES + l) * 8 +: 8] =
                inv_sbox(work_r[(int'(cnt_r) * LANES + l) * 8 +: 8]);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and handshake outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Work register, byte counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_r     <= 128'h0;
            cnt_r      <= {CW{1'b0}};
            out_data_r <= 128'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        work_r <= in_data;
                        cnt_r  <= {CW{1'b0}};
                    end
                end
                BUSY: begin
                    work_r <= work_s;
                    cnt_r  <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        out_data_r <= work_s;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_inv_sbox_seq.sv
// Self-checking bench for inv_sbox_seq: reference tables built from plain GF(2^8)
// arithmetic, directed handshake/reset sequences and randomized data blocks.
module tb_inv_sbox_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         sw_ir [4];
    logic         sw_ov [4];
    logic         sw_bz [4];
    logic [127:0] sw_od [4];

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    inv_sbox_seq #(.LANES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );
    inv_sbox_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_ir[0]), .in_data(in_data),
        .out_valid(sw_ov[0]), .out_ready(out_ready), .out_data(sw_od[0]), .busy(sw_bz[0])
    );
    inv_sbox_seq #(.LANES(2)) u_l2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_ir[1]), .in_data(in_data),
        .out_valid(sw_ov[1]), .out_ready(out_ready), .out_data(sw_od[1]), .busy(sw_bz[1])
    );
    inv_sbox_seq #(.LANES(8)) u_l8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_ir[2]), .in_data(in_data),
        .out_valid(sw_ov[2]), .out_ready(out_ready), .out_data(sw_od[2]), .busy(sw_bz[2])
    );
    inv_sbox_seq #(.LANES(16)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_ir[3]), .in_data(in_data),
        .out_valid(sw_ov[3]), .out_ready(out_ready), .out_data(sw_od[3]), .busy(sw_bz[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] aes_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] f;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && aes_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            f = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            fwd_tbl[x] = f;
            inv_tbl[f] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_state(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tbl[d[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block on the LANES=4 instance with 'hold' cycles of backpressure in DONE.
    task automatic run_block(input logic [127:0] data, input int hold, output logic [127:0] res);
        int   k;
        logic saw_ready;
        logic [127:0] got;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        chk("idle_in_ready", 128'(in_ready), 128'd1);
        in_valid  = 1'b1;
        in_data   = data;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        saw_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            if (in_ready) saw_ready = 1'b1;
            tick();
            k++;
        end
        chk("latency", 128'(k), 128'd4);
        chk("ready_low_busy", 128'(saw_ready), 128'd0);
        chk("busy_in_done", 128'(busy), 128'd1);
        got = out_data;
        chk("data", got, model_state(data));
        in_valid = 1'b1;
        in_data  = ~data;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", 128'(out_valid), 128'd1);
            chk("hold_data", out_data, got);
            chk("hold_ready", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_valid", 128'(out_valid), 128'd0);
        chk("release_ready", 128'(in_ready), 128'd1);
        chk("release_busy", 128'(busy), 128'd0);
        chk("data_kept", out_data, got);
        out_ready = 1'b0;
        res = got;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] d;
        logic [127:0] exp;
        logic [7:0]   perm [256];
        logic [7:0]   tmp;
        int           j;
        int           k;
        int           first_k [4];
        logic [127:0] sw_res [4];
        int           lanes_tab [4];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 128'h0;
        out_ready = 1'b0;
        build_tables();
        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_data", out_data, 128'h0);
        rst = 1'b0;
        tick();

        // Spot values from the AES inverse table.
        run_block(128'h63636363636363636363_52ED16007C63, 2, res);
        chk("spot", res, 128'h00000000000000000000_4853FF520100);

        // Exhaustive bytes in random order.
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int b = 0; b < 16; b++) begin
            for (int q = 0; q < 16; q++) d[8*q +: 8] = perm[b*16 + q];
            run_block(d, int'($urandom_range(3, 0)), res);
        end

        // Round trip through the forward table.
        for (int b = 0; b < 16; b++) begin
            for (int q = 0; q < 16; q++) begin
                d[8*q +: 8]   = fwd_tbl[b*16 + q];
                exp[8*q +: 8] = 8'(b*16 + q);
            end
            run_block(d, 0, res);
            chk("round_trip", res, exp);
        end

        // out_valid lasts one cycle with out_ready high; next accept at T+N+2.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        d         = in_data;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk("or1_latency", 128'(k), 128'd4);
        chk("or1_data", out_data, model_state(d));
        tick();
        chk("or1_valid_drop", 128'(out_valid), 128'd0);
        chk("or1_ready_back", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("or1_reaccept", 128'(busy), 128'd1);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        tick();
        out_ready = 1'b0;

        // Backpressure for 10 cycles plus random blocks.
        run_block({$urandom, $urandom, $urandom, $urandom}, 10, res);
        for (int b = 0; b < 6; b++) begin
            run_block({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(4, 0)), res);
        end

        // Reset in the second BUSY cycle.
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_out_data", out_data, 128'h0);
        run_block({16{8'h63}}, 1, res);
        chk("after_rst_63", res, 128'h0);

        // Lane sweep on a common state.
        lanes_tab = '{1, 2, 8, 16};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_data   = 128'h000102030405060708090A0B0C0D0E0F;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            first_k[i] = -1;
            sw_res[i]  = 128'h0;
        end
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (sw_ov[i] && first_k[i] < 0) begin
                    first_k[i] = c;
                    sw_res[i]  = sw_od[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sweep_latency_l%0d", lanes_tab[i]), 128'(first_k[i]), 128'(16 / lanes_tab[i]));
            chk($sformatf("sweep_data_l%0d", lanes_tab[i]), sw_res[i],
                model_state(128'h000102030405060708090A0B0C0D0E0F));
            chk($sformatf("sweep_idle_l%0d", lanes_tab[i]), 128'({sw_ir[i], sw_bz[i]}), 128'd2);
        end
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
